rand_range: RTL and testbench
=============================

// Module: rand_range
// PURPOSE
//  Consumer of the 8-bit LFSR generator output. Turns the free-running random byte into an
//  unbiased value in [0, bound) on request, for mutation/selection logic in the evolution engine.
//  Uses rejection sampling against a power-of-two mask, with a bounded retry count and a subtract
//  fallback. Sits between the LFSR and any client needing a range-limited random number.
// PARAMETERS
//  WIDTH      8  width of rand_in, bound, value
//  MAX_TRIES  4  samples taken before fallback; legal range 1..15
// PORTS
//  clk       in   1      system clock, all state on posedge
//  rst       in   1      asynchronous, active-low reset
//  rand_in   in   WIDTH  LFSR output, new value every cycle
//  req       in   1      start request, sampled only while busy=0
//  bound     in   WIDTH  exclusive upper limit, captured with req
//  busy      out  1      high from the cycle after req is accepted until valid drops
//  valid     out  1      one-cycle pulse, value is meaningful
//  value     out  WIDTH  result, held until the next accepted req
//  fallback  out  1      qualifies valid: result came from the subtract path
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, busy=0, valid=0, value=0, fallback=0, try_cnt=0.
//    A request in flight is discarded and no valid is produced for it.
//  - FSM states: IDLE, SAMPLE, DONE. All outputs are registered.
//  - IDLE, req=1, bound>=2: capture bound_q=bound; mask_q=smear(bound-1) (all bits below and
//    including MSB of bound-1 set); try_cnt=0; go to SAMPLE.
//  - IDLE, req=1, bound<=1: value=0, fallback=0; go to DONE (latency 1).
//  - SAMPLE, each cycle: cand = rand_in & mask_q.
//    - cand < bound_q: value=cand, fallback=0; go to DONE.
//    - Otherwise, if try_cnt == MAX_TRIES-1: value=cand-bound_q (always < bound_q, because
//      mask_q < 2*bound_q), fallback=1; go to DONE.
//    - Otherwise: try_cnt++; stay in SAMPLE.
//  - DONE: valid=1 for exactly one cycle, then unconditionally return to IDLE.
//  - Latency from req edge to valid: 2 cycles minimum, MAX_TRIES+1 cycles maximum.
//    Back-to-back requests: the next req is accepted in the IDLE cycle following DONE.
//  - req while busy=1 is ignored and not queued. bound changes while busy are ignored.
//  - All comparisons are unsigned WIDTH-bit. try_cnt is 4 bits.
// CONFIGURATION
//  RAND_RANGE_STATS_EN defined:
//   - Adds output reject_cnt [15:0]: +1 per rejected SAMPLE cycle, saturates at 16'hFFFF.
//   - Adds output fb_cnt [7:0]: +1 per fallback result, saturates at 8'hFF.
//   - Both counters are cleared by rst only.
//  Not defined: neither port nor either counter exists; all other behaviour is identical.
// STRUCTURE
//  - Shared package rand_pkg: RAND_W=8, state encoding (IDLE=2'd0, SAMPLE=2'd1, DONE=2'd2),
//    smear-mask function.
//  - One sub-module range_mask: combinational, bound-1 -> mask. Instanced once, output registered.
//  - Remainder (FSM, try counter, datapath compare/subtract, optional stats) is in rand_range.
// TESTING
//  1. rst=0 mid-SAMPLE with bound=10 -> busy, valid, value, fallback all 0 immediately;
//     no valid after release.
//  2. req, bound=10, rand_in=8'h23 -> mask 8'h0F, cand 3; value=3, valid at req+2, fallback=0.
//  3. bound=10, rand_in 8'h0E,8'h0C,8'h0B,8'h0F (MAX_TRIES=4) -> fallback=1, value=5 at req+5.
//  4. bound=1 then bound=0 -> value=0, valid at req+1 each time, SAMPLE never entered.
//  5. bound=200 (mask 8'hFF), rand_in 8'hC8 then 8'h05 -> value=5 at req+3; req pulsed while
//     busy -> ignored, exactly one valid.
//  6. With RAND_RANGE_STATS_EN, run test 3 twice -> reject_cnt=6, fb_cnt=2.
//     Force 300 fallbacks -> fb_cnt holds at 8'hFF.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared definitions for the range-limited random number block:
// data width, FSM state encoding and the bit-smear mask helper.
package rand_pkg;

   localparam int unsigned RAND_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Sets every bit at and below the most significant set bit of x.
   function automatic logic [31:0] smear(input logic [31:0] x);
      logic [31:0] r;
      r = x;
      r = r | (r >> 1);
      r = r | (r >> 2);
      r = r | (r >> 4);
      r = r | (r >> 8);
      r = r | (r >> 16);
      return r;
   endfunction

endpackage

// File: rtl/range_mask.sv
// range_mask: combinational power-of-two sampling mask covering bound-1.
module range_mask import rand_pkg::*; #(
   parameter int unsigned WIDTH = RAND_W
) (
   input  logic [WIDTH-1:0] bound_m1,
   output logic [WIDTH-1:0] mask
);

   always_comb begin
      mask = WIDTH'(smear(32'(bound_m1)));
   end

endmodule

// File: rtl/rand_range.sv
// rand_range: rejection-sampled unbiased value in [0, bound) from a free-running LFSR byte,
// with bounded retries and a subtract fallback. RAND_RANGE_STATS_EN adds saturating counters.
module rand_range import rand_pkg::*; #(
   parameter int unsigned WIDTH     = RAND_W,
   parameter int unsigned MAX_TRIES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] rand_in,
   input  logic             req,
   input  logic [WIDTH-1:0] bound,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] value,
   output logic             fallback
`ifdef RAND_RANGE_STATS_EN
   ,
   output logic [15:0]      reject_cnt,
   output logic [7:0]       fb_cnt
`endif
);

   localparam logic [3:0]       LAST_TRY = 4'(MAX_TRIES - 1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] bound_q, bound_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic [3:0]       try_q, try_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic             fb_q, fb_d;
   logic [WIDTH-1:0] bound_m1, mask_w, cand;
   logic             hit, last_try;

   assign bound_m1 = bound - ONE;

   range_mask #(.WIDTH(WIDTH)) u_range_mask (
      .bound_m1 (bound_m1),
      .mask     (mask_w)
   );

   assign cand     = rand_in & mask_q;
   assign hit      = (cand < bound_q);
   assign last_try = (try_q == LAST_TRY);

   always_comb begin
      state_d = state_q;
      bound_d = bound_q;
      mask_d  = mask_q;
      value_d = value_q;
      try_d   = try_q;
      fb_d    = fb_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (bound > ONE) begin
                  bound_d = bound;
                  mask_d  = mask_w;
                  try_d   = '0;
                  state_d = SAMPLE;
               end else begin
                  value_d = '0;
                  fb_d    = 1'b0;
                  state_d = DONE;
               end
            end
         end
         SAMPLE: begin
            if (hit) begin
               value_d = cand;
               fb_d    = 1'b0;
               state_d = DONE;
            end else if (last_try) begin
               // mask_q < 2*bound_q, so a rejected candidate minus bound_q is in range
               value_d = cand - bound_q;
               fb_d    = 1'b1;
               state_d = DONE;
            end else begin
               try_d = try_q + 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      valid_d = (state_d == DONE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         bound_q <= '0;
         mask_q  <= '0;
         value_q <= '0;
         try_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         fb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         bound_q <= bound_d;
         mask_q  <= mask_d;
         value_q <= value_d;
         try_q   <= try_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         fb_q    <= fb_d;
      end
   end

   assign busy     = busy_q;
   assign valid    = valid_q;
   assign value    = value_q;
   assign fallback = fb_q;

`ifdef RAND_RANGE_STATS_EN
   logic [15:0] rej_q, rej_d;
   logic [7:0]  fbc_q, fbc_d;
   logic        in_sample;

   assign in_sample = (state_q == SAMPLE) && !hit;

   always_comb begin
      rej_d = rej_q;
      fbc_d = fbc_q;
      if (in_sample && !last_try && (rej_q != '1)) rej_d = rej_q + 16'd1;
      if (in_sample && last_try && (fbc_q != '1))  fbc_d = fbc_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rej_q <= '0;
         fbc_q <= '0;
      end else begin
         rej_q <= rej_d;
         fbc_q <= fbc_d;
      end
   end

   assign reject_cnt = rej_q;
   assign fb_cnt     = fbc_q;
`endif

endmodule

// File: tb/tb_rand_range.sv
// Self-checking bench for rand_range: directed cases plus randomized requests
// checked against a behavioural rejection-sampling model.
`timescale 1ns/1ps
module tb_rand_range;

   localparam int unsigned MT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       req;
   logic [7:0] rand_in;
   logic [7:0] bound;
   logic       busy;
   logic       valid;
   logic [7:0] value;
   logic       fallback;
`ifdef RAND_RANGE_STATS_EN
   logic [15:0] reject_cnt;
   logic [7:0]  fb_cnt;
`endif

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] samp [0:15];
   int         exp_rej  = 0;
   int         exp_fbc  = 0;

   always #5 clk = ~clk;

   rand_range #(.WIDTH(8), .MAX_TRIES(MT)) dut (
      .clk        (clk),
      .rst        (rst),
      .rand_in    (rand_in),
      .req        (req),
      .bound      (bound),
      .busy       (busy),
      .valid      (valid),
      .value      (value),
      .fallback   (fallback)
`ifdef RAND_RANGE_STATS_EN
      ,
      .reject_cnt (reject_cnt),
      .fb_cnt     (fb_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Smallest all-ones mask covering b-1; candidates are the masked samples in order.
   // n = number of samples consumed (0 when bound <= 1).
   function automatic void model(input logic [7:0] b, output logic [7:0] v,
                                 output logic f, output int n);
      int unsigned bb, m, c;
      bb = b;
      v = 8'd0; f = 1'b0; n = 0;
      if (bb < 2) return;
      m = 1;
      while (m < bb - 1) m = m * 2 + 1;
      for (int t = 0; t < int'(MT); t++) begin
         c = samp[t] & m;
         if (c < bb) begin
            v = 8'(c); n = t + 1;
            return;
         end
      end
      v = 8'(c - bb); f = 1'b1; n = MT;
   endfunction

   task automatic run_req(input logic [7:0] b, input bit poke);
      logic [7:0] ev;
      logic       ef;
      int         en, n;
      model(b, ev, ef, en);
      if (b >= 2) begin
         if (ef) begin
            exp_rej = (exp_rej + int'(MT) - 1 > 65535) ? 65535 : exp_rej + int'(MT) - 1;
            exp_fbc = (exp_fbc < 255) ? exp_fbc + 1 : 255;
         end else begin
            exp_rej = (exp_rej + en - 1 > 65535) ? 65535 : exp_rej + en - 1;
         end
      end
      req = 1'b1; bound = b; rand_in = 8'($urandom);
      step();
      req = 1'b0; bound = 8'($urandom);
      check("busy_after_accept", busy, 1);
      n = 0;
      while (valid !== 1'b1 && n < 20) begin
         rand_in = samp[n % 16];
         req = poke && (n == 0);
         step();
         n++;
      end
      req = 1'b0;
      check("latency", n, en);
      check("value", value, ev);
      check("fallback", fallback, ef);
      check("busy_with_valid", busy, 1);
      step();
      check("valid_one_cycle", valid, 0);
      check("busy_clear", busy, 0);
      check("value_held", value, ev);
      step();
      check("no_extra_request", busy, 0);
`ifdef RAND_RANGE_STATS_EN
      check("reject_cnt", reject_cnt, exp_rej);
      check("fb_cnt", fb_cnt, exp_fbc);
`endif
   endtask

   task automatic set_t3();
      samp[0] = 8'h0E; samp[1] = 8'h0C; samp[2] = 8'h0B; samp[3] = 8'h0F;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      bit         bias;
      rst = 1'b0; req = 1'b0; bound = 8'd0; rand_in = 8'd0;
      for (int i = 0; i < 16; i++) samp[i] = 8'd0;
      #1;
      check("reset_busy", busy, 0);
      check("reset_valid", valid, 0);
      check("reset_value", value, 0);
      check("reset_fallback", fallback, 0);
      repeat (2) step();
      rst = 1'b1;
      step();

      samp[0] = 8'h23;
      run_req(8'd10, 1'b0);

      set_t3();
      run_req(8'd10, 1'b0);

      run_req(8'd1, 1'b0);
      run_req(8'd0, 1'b0);

      samp[0] = 8'hC8; samp[1] = 8'h05;
      run_req(8'd200, 1'b1);

      // Reset while sampling: outputs clear at once and the request is dropped
      req = 1'b1; bound = 8'd10; rand_in = 8'hFF;
      step();
      req = 1'b0; rand_in = 8'hFF;
      step();
      rst = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_valid", valid, 0);
      check("midrst_value", value, 0);
      check("midrst_fallback", fallback, 0);
      exp_rej = 0; exp_fbc = 0;
      step();
      rst = 1'b1;
      rand_in = 8'h03;
      for (int i = 0; i < 6; i++) begin
         step();
         check("no_valid_after_reset", valid, 0);
         check("idle_after_reset", busy, 0);
      end

      for (int i = 0; i < 60; i++) begin
         b = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(2, 255));
         bias = ($urandom_range(0, 2) == 0);
         for (int k = 0; k < 16; k++)
            samp[k] = bias ? 8'(255 - $urandom_range(0, 7)) : 8'($urandom);
         run_req(b, bit'($urandom_range(0, 1)));
      end

`ifdef RAND_RANGE_STATS_EN
      rst = 1'b0;
      #1;
      step();
      rst = 1'b1;
      exp_rej = 0; exp_fbc = 0;
      set_t3();
      run_req(8'd10, 1'b0);
      run_req(8'd10, 1'b0);
      check("stats_t3_reject", reject_cnt, 16'd6);
      check("stats_t3_fb", fb_cnt, 8'd2);
      for (int i = 0; i < 298; i++) run_req(8'd10, 1'b0);
      check("stats_fb_saturated", fb_cnt, 8'hFF);
      check("stats_reject_total", reject_cnt, 16'd900);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
